// File: rtl/roi_read_scheduler_pkg.sv
// Shared types and helpers for the ROI read scheduler: FSM encoding, ROI field
// geometry and packed-field slicing.
package roi_read_scheduler_pkg;

    localparam int unsigned RoiFieldWd = 16;
    localparam int unsigned RoiMax     = 8;
    localparam int unsigned RoiIdxWd   = 3;

    typedef logic [RoiFieldWd*RoiMax-1:0] roi_vec_t;

    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StRoiSel,
        StFvalLead,
        StLineReq,
        StLineWait,
        StRoiEnd,
        StGap
    } state_e;

    // Packed config vectors are zero-extended to RoiMax slots before slicing.
    function automatic logic [RoiFieldWd-1:0] roi_field(input roi_vec_t vec,
                                                        input logic [RoiIdxWd-1:0] idx);
        return vec[idx*RoiFieldWd +: RoiFieldWd];
    endfunction

endpackage

// File: rtl/roi_next_sel.sv
// Priority search: lowest valid ROI index at or above a start index.
module roi_next_sel
    import roi_read_scheduler_pkg::*;
#(
    parameter int unsigned RoiNum = 4
) (
    input  logic [RoiNum-1:0]   valid_i,
    input  logic [RoiIdxWd:0]   start_i,
    output logic                found_o,
    output logic [RoiIdxWd-1:0] idx_o
);

    // Scanning downwards lets the lowest qualifying index win.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = int'(RoiNum) - 1; i >= 0; i--) begin
            if (valid_i[i] && ((RoiIdxWd+1)'(i) >= start_i)) begin
                found_o = 1'b1;
                idx_o   = RoiIdxWd'(i);
            end
        end
    end

endmodule

// File: rtl/roi_read_scheduler.sv
// Read-side sequencer of the multi-ROI frame buffer: walks the valid ROIs of a
// resident frame, issues one line request per ROI line and frames each ROI with o_fval.
module roi_read_scheduler
    import roi_read_scheduler_pkg::*;
#(
    parameter int unsigned ROI_NUM    = 4,
    parameter int unsigned ADDR_WD    = 24,
    parameter int unsigned FVAL_LEAD  = 4,
    parameter int unsigned FVAL_TRAIL = 4,
    parameter int unsigned FVAL_GAP   = 20
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          i_stream_enable,
    input  logic                          i_frame_ready,
    input  logic [ADDR_WD-1:0]            iv_frame_base,
    input  logic [15:0]                   iv_line_pitch,
    input  logic [ROI_NUM-1:0]            iv_roi_en,
    input  logic [ROI_NUM*RoiFieldWd-1:0] iv_roi_offset_x,
    input  logic [ROI_NUM*RoiFieldWd-1:0] iv_roi_offset_y,
    input  logic [ROI_NUM*RoiFieldWd-1:0] iv_roi_width,
    input  logic [ROI_NUM*RoiFieldWd-1:0] iv_roi_height,
    output logic                          o_rd_req,
    output logic [ADDR_WD-1:0]            ov_rd_addr,
    output logic [15:0]                   ov_rd_len,
    output logic [2:0]                    ov_rd_roi_id,
    input  logic                          i_rd_ack,
    input  logic                          i_rd_done,
    output logic                          o_fval,
    output logic                          o_frame_done,
    output logic                          o_busy,
    output logic                          o_cfg_err
);

    state_e state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [15:0] line_q;
    logic [RoiIdxWd-1:0] roi_idx_q;
    logic pending_q, stop_q, fval_q, frame_done_q, cfg_err_q;

    logic [ADDR_WD-1:0] base_q, addr_q;
    logic [15:0] pitch_q, len_q, height_q;
    logic [ROI_NUM-1:0] valid_q;
    logic [ROI_NUM*RoiFieldWd-1:0] ox_q, oy_q, w_q, h_q;

    logic [ROI_NUM-1:0] valid_now;
    logic cfg_err_now;
    logic [RoiIdxWd:0] sel_start;
    logic sel_found;
    logic [RoiIdxWd-1:0] sel_idx;
    logic [RoiFieldWd-1:0] sel_ox, sel_oy, sel_w, sel_h;
    logic [31:0] sel_prod;

    always_comb begin
        valid_now = '0;
        for (int k = 0; k < int'(ROI_NUM); k++) begin
            valid_now[k] = iv_roi_en[k]
                && (roi_field(roi_vec_t'(iv_roi_width), RoiIdxWd'(k)) != '0)
                && (roi_field(roi_vec_t'(iv_roi_height), RoiIdxWd'(k)) != '0);
        end
        cfg_err_now = |(iv_roi_en & ~valid_now);
    end

    roi_next_sel #(
        .RoiNum (ROI_NUM)
    ) u_next_sel (
        .valid_i (valid_q),
        .start_i (sel_start),
        .found_o (sel_found),
        .idx_o   (sel_idx)
    );

    assign sel_ox   = roi_field(roi_vec_t'(ox_q), sel_idx);
    assign sel_oy   = roi_field(roi_vec_t'(oy_q), sel_idx);
    assign sel_w    = roi_field(roi_vec_t'(w_q), sel_idx);
    assign sel_h    = roi_field(roi_vec_t'(h_q), sel_idx);
    assign sel_prod = 32'(sel_oy) * 32'(pitch_q);

    always_comb begin
        state_d   = state_q;
        sel_start = {1'b0, roi_idx_q};
        case (state_q)
            StIdle: begin
                if (i_stream_enable && (i_frame_ready || pending_q)) state_d = StLatch;
            end
            StLatch:    state_d = (|valid_now) ? StRoiSel : StIdle;
            StRoiSel:   state_d = sel_found ? StFvalLead : StIdle;
            StFvalLead: if (cnt_q == 8'(FVAL_LEAD)) state_d = StLineReq;
            StLineReq:  if (i_rd_ack) state_d = StLineWait;
            StLineWait: begin
                if (i_rd_done) state_d = (line_q + 16'd1 == height_q) ? StRoiEnd : StLineReq;
            end
            StRoiEnd:   if (cnt_q == 8'(FVAL_TRAIL - 1)) state_d = StGap;
            StGap: begin
                // Look past the ROI just finished for another candidate.
                sel_start = {1'b0, roi_idx_q} + 1'b1;
                if (cnt_q == 8'(FVAL_GAP - 1)) begin
                    state_d = (sel_found && !stop_q && i_stream_enable) ? StRoiSel : StIdle;
                end
            end
            default:    state_d = StIdle;
        endcase
        cnt_d = (state_d != state_q) ? 8'd0 : cnt_q + 8'd1;
    end

    // o_fval trails the state by one cycle, stretching lead and trail to the
    // downstream edge timing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            fval_q       <= 1'b0;
            frame_done_q <= 1'b0;
            pending_q    <= 1'b0;
            stop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            fval_q       <= (state_q == StFvalLead) || (state_q == StLineReq)
                            || (state_q == StLineWait) || (state_q == StRoiEnd);
            frame_done_q <= (state_q == StGap) && (state_d == StIdle);
            if (state_q == StIdle && state_d == StLatch) begin
                pending_q <= 1'b0;
            end else if (state_q != StIdle && i_frame_ready) begin
                pending_q <= 1'b1;
            end
            if (state_q == StLatch) begin
                stop_q <= 1'b0;
            end else if (state_q != StIdle && !i_stream_enable) begin
                stop_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_q    <= '0;
            pitch_q   <= '0;
            valid_q   <= '0;
            ox_q      <= '0;
            oy_q      <= '0;
            w_q       <= '0;
            h_q       <= '0;
            cfg_err_q <= 1'b0;
            roi_idx_q <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            height_q  <= '0;
            line_q    <= '0;
        end else begin
            if (state_q == StLatch) begin
                base_q    <= iv_frame_base;
                pitch_q   <= iv_line_pitch;
                valid_q   <= valid_now;
                ox_q      <= iv_roi_offset_x;
                oy_q      <= iv_roi_offset_y;
                w_q       <= iv_roi_width;
                h_q       <= iv_roi_height;
                cfg_err_q <= cfg_err_now;
                roi_idx_q <= '0;
            end
            if (state_q == StRoiSel && sel_found) begin
                roi_idx_q <= sel_idx;
                addr_q    <= base_q + ADDR_WD'(sel_prod) + ADDR_WD'(sel_ox);
                len_q     <= sel_w;
                height_q  <= sel_h;
                line_q    <= '0;
            end
            if (state_q == StLineWait && i_rd_done) begin
                line_q <= line_q + 16'd1;
                addr_q <= addr_q + ADDR_WD'(pitch_q);
            end
            if (state_q == StGap && state_d == StRoiSel) begin
                roi_idx_q <= roi_idx_q + 1'b1;
            end
        end
    end

    assign o_rd_req     = (state_q == StLineReq);
    assign o_busy       = (state_q != StIdle);
    assign o_fval       = fval_q;
    assign o_frame_done = frame_done_q;
    assign o_cfg_err    = cfg_err_q;
    assign ov_rd_addr   = addr_q;
    assign ov_rd_len    = len_q;
    assign ov_rd_roi_id = roi_idx_q;

endmodule

// File: tb/tb_roi_read_scheduler.sv
// Scoreboard bench for roi_read_scheduler: tests queue expected line requests,
// a monitor pops and compares each accepted request.
module tb_roi_read_scheduler;

    localparam int unsigned RN = 4;
    localparam int unsigned AW = 24;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic i_stream_enable = 1'b1;
    logic i_frame_ready = 1'b0;
    logic [AW-1:0] iv_frame_base = '0;
    logic [15:0] iv_line_pitch = '0;
    logic [RN-1:0] iv_roi_en = '0;
    logic [RN*16-1:0] iv_roi_offset_x = '0, iv_roi_offset_y = '0;
    logic [RN*16-1:0] iv_roi_width = '0, iv_roi_height = '0;
    logic o_rd_req, o_fval, o_frame_done, o_busy, o_cfg_err;
    logic [AW-1:0] ov_rd_addr;
    logic [15:0] ov_rd_len;
    logic [2:0] ov_rd_roi_id;
    logic i_rd_ack, i_rd_done;

    always #5 clk = ~clk;

    roi_read_scheduler #(
        .ROI_NUM (RN),
        .ADDR_WD (AW)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .i_stream_enable (i_stream_enable),
        .i_frame_ready   (i_frame_ready),
        .iv_frame_base   (iv_frame_base),
        .iv_line_pitch   (iv_line_pitch),
        .iv_roi_en       (iv_roi_en),
        .iv_roi_offset_x (iv_roi_offset_x),
        .iv_roi_offset_y (iv_roi_offset_y),
        .iv_roi_width    (iv_roi_width),
        .iv_roi_height   (iv_roi_height),
        .o_rd_req        (o_rd_req),
        .ov_rd_addr      (ov_rd_addr),
        .ov_rd_len       (ov_rd_len),
        .ov_rd_roi_id    (ov_rd_roi_id),
        .i_rd_ack        (i_rd_ack),
        .i_rd_done       (i_rd_done),
        .o_fval          (o_fval),
        .o_frame_done    (o_frame_done),
        .o_busy          (o_busy),
        .o_cfg_err       (o_cfg_err)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   len;
        logic [2:0]    id;
    } req_t;

    req_t exp_q[$];
    req_t got;
    int n_checks = 0, n_fail = 0;
    int frame_done_cnt = 0, fval_rises = 0, xfer_cnt = 0;
    int cur_low = 0, cur_high = 0, last_high = 0, min_low = 1000;
    int hold_cnt = 0, max_hold = 0;
    bit fall_seen = 0, fval_prev = 0, req_prev = 0;
    logic [AW-1:0] hold_addr;
    logic [15:0] hold_len;
    int ack_delay = 0, ack_wait = 0;
    bit done_due = 0, hold_done = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic check_ge(input string name, input int act, input int min);
        n_checks++;
        if (act < min) begin
            n_fail++;
            $display("FAIL %s: actual %0d, required >= %0d", name, act, min);
        end
    endtask

    // Read engine model: ack after ack_delay cycles of req, done one cycle later.
    initial begin
        i_rd_ack = 1'b0;
        i_rd_done = 1'b0;
        forever begin
            @(negedge clk);
            i_rd_ack = 1'b0;
            i_rd_done = 1'b0;
            if (!reset_n) begin
                ack_wait = 0;
                done_due = 0;
            end else if (done_due) begin
                if (!hold_done) begin
                    i_rd_done = 1'b1;
                    done_due = 0;
                end
            end else if (o_rd_req) begin
                if (ack_wait >= ack_delay) begin
                    i_rd_ack = 1'b1;
                    ack_wait = 0;
                    done_due = 1;
                end else begin
                    ack_wait++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (o_frame_done) frame_done_cnt++;
            if (o_fval && !fval_prev) begin
                fval_rises++;
                if (fall_seen && cur_low < min_low) min_low = cur_low;
                cur_high = 0;
            end
            if (!o_fval && fval_prev) begin
                fall_seen = 1;
                cur_low = 0;
                last_high = cur_high;
            end
            if (o_fval) cur_high++;
            else cur_low++;
            fval_prev = o_fval;
            if (o_rd_req) begin
                if (req_prev) begin
                    check("hold_addr", int'(ov_rd_addr), int'(hold_addr));
                    check("hold_len", int'(ov_rd_len), int'(hold_len));
                    hold_cnt++;
                    if (hold_cnt > max_hold) max_hold = hold_cnt;
                end else begin
                    hold_addr = ov_rd_addr;
                    hold_len = ov_rd_len;
                    hold_cnt = 0;
                end
                if (i_rd_ack) begin
                    xfer_cnt++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_req: actual addr 0x%0h, required no request",
                                 ov_rd_addr);
                    end else begin
                        got = exp_q.pop_front();
                        check("req_addr", int'(ov_rd_addr), int'(got.addr));
                        check("req_len", int'(ov_rd_len), int'(got.len));
                        check("req_roi_id", int'(ov_rd_roi_id), int'(got.id));
                    end
                end
            end
            req_prev = o_rd_req && !i_rd_ack;
        end
    end

    task automatic clear_rois();
        iv_roi_en = '0;
        iv_roi_offset_x = '0;
        iv_roi_offset_y = '0;
        iv_roi_width = '0;
        iv_roi_height = '0;
    endtask

    task automatic set_roi(input int k, input int x, input int y, input int w, input int h);
        iv_roi_en[k] = 1'b1;
        iv_roi_offset_x[16*k +: 16] = 16'(x);
        iv_roi_offset_y[16*k +: 16] = 16'(y);
        iv_roi_width[16*k +: 16] = 16'(w);
        iv_roi_height[16*k +: 16] = 16'(h);
    endtask

    task automatic push(input int addr, input int len, input int id);
        req_t e;
        e.addr = AW'(addr);
        e.len = 16'(len);
        e.id = 3'(id);
        exp_q.push_back(e);
    endtask

    task automatic start_test();
        frame_done_cnt = 0;
        fval_rises = 0;
        xfer_cnt = 0;
        fall_seen = 0;
        min_low = 1000;
        max_hold = 0;
    endtask

    task automatic pulse_ready();
        @(negedge clk);
        i_frame_ready = 1'b1;
        @(negedge clk);
        i_frame_ready = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int c = 0;
        while (frame_done_cnt < target && c < budget) begin
            @(negedge clk);
            c++;
        end
        #2;
        check("frame_done_in_time", int'(frame_done_cnt >= target), 1);
    endtask

    task automatic wait_xfers(input int target, input int budget);
        int c = 0;
        while (xfer_cnt < target && c < budget) begin
            @(negedge clk);
            c++;
        end
        #2;
        check("xfer_in_time", int'(xfer_cnt >= target), 1);
    endtask

    initial begin
        int first_fval, first_req;

        // Reset values
        #12;
        check("rst_rd_req", int'(o_rd_req), 0);
        check("rst_fval", int'(o_fval), 0);
        check("rst_busy", int'(o_busy), 0);
        check("rst_frame_done", int'(o_frame_done), 0);
        check("rst_cfg_err", int'(o_cfg_err), 0);
        check("rst_addr", int'(ov_rd_addr), 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single ROI, immediate ack/done, with edge timing
        start_test();
        clear_rois();
        iv_frame_base = 24'h100;
        iv_line_pitch = 16;
        set_roi(0, 2, 1, 8, 3);
        push('h112, 8, 0);
        push('h122, 8, 0);
        push('h132, 8, 0);
        first_fval = 0;
        first_req = 0;
        @(negedge clk);
        i_frame_ready = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (n == 1) i_frame_ready = 1'b0;
            #2;
            if (o_fval && first_fval == 0) first_fval = n;
            if (o_rd_req && first_req == 0) first_req = n;
        end
        check("fval_rise_cycle", first_fval, 4);
        check("first_req_cycle", first_req, 8);
        wait_frames(1, 300);
        repeat (5) @(negedge clk);
        #2;
        check("t1_frame_done_cnt", frame_done_cnt, 1);
        check("t1_fval_pulses", fval_rises, 1);
        check_ge("t1_fval_high_len", last_high, 14);
        check("t1_cfg_err", int'(o_cfg_err), 0);
        check("t1_queue_empty", exp_q.size(), 0);
        check("t1_busy", int'(o_busy), 0);

        // ROI1 enabled with zero width: flagged and skipped
        start_test();
        clear_rois();
        set_roi(0, 0, 0, 4, 1);
        set_roi(1, 0, 0, 0, 2);
        set_roi(2, 4, 2, 4, 2);
        push('h100, 4, 0);
        push('h124, 4, 2);
        push('h134, 4, 2);
        pulse_ready();
        wait_frames(1, 400);
        repeat (5) @(negedge clk);
        #2;
        check("t2_cfg_err", int'(o_cfg_err), 1);
        check("t2_fval_pulses", fval_rises, 2);
        check_ge("t2_fval_gap", min_low, 20);
        check("t2_frame_done_cnt", frame_done_cnt, 1);
        check("t2_queue_empty", exp_q.size(), 0);

        // Ack held off for 5 cycles: request must stay stable
        start_test();
        clear_rois();
        iv_frame_base = 24'h200;
        set_roi(0, 0, 0, 8, 1);
        ack_delay = 5;
        push('h200, 8, 0);
        pulse_ready();
        wait_frames(1, 300);
        ack_delay = 0;
        #2;
        check("t3_hold_cycles", max_hold, 5);
        check("t3_xfers", xfer_cnt, 1);
        check("t3_cfg_err", int'(o_cfg_err), 0);

        // Three extra frame_ready pulses while busy: exactly one more frame
        start_test();
        clear_rois();
        iv_frame_base = 24'h400;
        set_roi(0, 0, 0, 4, 2);
        push('h400, 4, 0);
        push('h410, 4, 0);
        push('h400, 4, 0);
        push('h410, 4, 0);
        pulse_ready();
        repeat (3) @(negedge clk);
        for (int p = 0; p < 3; p++) begin
            pulse_ready();
            @(negedge clk);
        end
        wait_frames(2, 400);
        repeat (80) @(negedge clk);
        #2;
        check("t4_frame_done_cnt", frame_done_cnt, 2);
        check("t4_xfers", xfer_cnt, 4);
        check("t4_busy", int'(o_busy), 0);
        check_ge("t4_fval_gap", min_low, 20);
        check("t4_queue_empty", exp_q.size(), 0);

        // Stream enable dropped during ROI0 of 3
        start_test();
        clear_rois();
        iv_frame_base = 24'h500;
        set_roi(0, 0, 0, 4, 2);
        set_roi(1, 0, 4, 4, 2);
        set_roi(2, 8, 0, 4, 2);
        push('h500, 4, 0);
        push('h510, 4, 0);
        pulse_ready();
        wait_xfers(1, 100);
        i_stream_enable = 1'b0;
        wait_frames(1, 400);
        repeat (30) @(negedge clk);
        #2;
        i_stream_enable = 1'b1;
        check("t5_frame_done_cnt", frame_done_cnt, 1);
        check("t5_fval_pulses", fval_rises, 1);
        check("t5_xfers", xfer_cnt, 2);
        check("t5_busy", int'(o_busy), 0);
        check("t5_queue_empty", exp_q.size(), 0);

        // Reset in LINE_WAIT, then a fresh frame from ROI0
        start_test();
        clear_rois();
        iv_frame_base = 24'h300;
        set_roi(0, 0, 0, 4, 2);
        set_roi(1, 0, 1, 4, 1);
        hold_done = 1;
        push('h300, 4, 0);
        pulse_ready();
        wait_xfers(1, 100);
        @(negedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("rst_mid_rd_req", int'(o_rd_req), 0);
        check("rst_mid_fval", int'(o_fval), 0);
        check("rst_mid_busy", int'(o_busy), 0);
        check("rst_mid_addr", int'(ov_rd_addr), 0);
        check("rst_mid_len", int'(ov_rd_len), 0);
        hold_done = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        start_test();
        push('h300, 4, 0);
        push('h310, 4, 0);
        push('h310, 4, 1);
        pulse_ready();
        wait_frames(1, 400);
        repeat (5) @(negedge clk);
        #2;
        check("t6_xfers", xfer_cnt, 3);
        check("t6_fval_pulses", fval_rises, 2);
        check("t6_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
